// File: rtl/ts_chk.sv
// rtl/ts_chk.sv - receive-side checker for the 32-bit TS loopback test stream
`timescale 1ns/1ps
module ts_chk #(
  parameter int         PKT_WORDS = 48,
  parameter logic [7:0] SYNC_BYTE = 8'h47
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ts_data,
  input  logic        ts_valid,
  input  logic        ts_start,
  input  logic        ts_end,
  output logic        pkt_ok,
  output logic        pkt_err,
  output logic [3:0]  err_code,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt,
  output logic        locked
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
  localparam logic [7:0] LAST_W = 8'(PKT_WORDS);

  logic [1:0]  state_q, state_d;
  logic [7:0]  w_q, w_d;
  logic [3:0]  rx_ch_q, rx_ch_d, exp_ch_q, exp_ch_d;
  logic [7:0]  rx_pn_q, rx_pn_d, exp_pn_q, exp_pn_d;
  logic        seeded_q, seeded_d;
  logic        hdr_q, hdr_d, pay_q, pay_d, seq_q, seq_d;
  logic        ok_q, ok_d, err_q, err_d;
  logic [3:0]  code_q, code_d;
  logic [15:0] pcnt_q, pcnt_d, ecnt_q, ecnt_d;
  logic        locked_q, locked_d;

  logic        abort, done, begin1;
  logic [7:0]  w_nx, wm1, base;
  logic [31:0] exp_pay;

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    rx_ch_d  = rx_ch_q;
    rx_pn_d  = rx_pn_q;
    exp_ch_d = exp_ch_q;
    exp_pn_d = exp_pn_q;
    seeded_d = seeded_q;
    hdr_d    = hdr_q;
    pay_d    = pay_q;
    seq_d    = seq_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    locked_d = locked_q;
    abort    = 1'b0;
    done     = 1'b0;
    begin1   = 1'b0;

    // Payload word w carries bytes starting at 4*(w-2)-1; w-2 == w_q-1 for the incoming word.
    w_nx    = w_q + 8'd1;
    wm1     = w_q - 8'd1;
    base    = {wm1[5:0], 2'b00};
    exp_pay = {base - 8'd1, base, base + 8'd1, base + 8'd2};

    case (state_q)
      S_IDLE: begin1 = ts_valid & ts_start;
      S_HDR: begin
        if (!ts_valid) begin
          abort = 1'b1;
        end else if (ts_start) begin
          abort  = 1'b1;
          begin1 = 1'b1;
        end else begin
          w_d     = 8'd2;
          hdr_d   = hdr_q | (ts_data[31:24] != SYNC_BYTE) | (ts_data[15:8] != 8'h01)
                          | (ts_data[7:0] != 8'h02);
          rx_pn_d = ts_data[23:16];
          seq_d   = seeded_q & ((rx_ch_q != exp_ch_q) | (ts_data[23:16] != exp_pn_q));
          if (ts_end) abort = 1'b1;
          else state_d = S_PAY;
        end
      end
      S_PAY: begin
        if (!ts_valid) begin
          abort = 1'b1;
        end else if (ts_start) begin
          abort  = 1'b1;
          begin1 = 1'b1;
        end else begin
          w_d   = w_nx;
          pay_d = pay_q | (ts_data != exp_pay);
          if (ts_end && w_nx == LAST_W) done = 1'b1;
          else if (ts_end || w_nx == LAST_W) abort = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Aborts leave the sequence expectation untouched so the retransmitted packet still matches.
    if (abort) begin
      err_d   = 1'b1;
      code_d  = {pay_d, 1'b0, hdr_d, 1'b1};
      state_d = S_IDLE;
    end

    if (done) begin
      code_d   = {pay_d, seq_d, hdr_d, 1'b0};
      ok_d     = ~(pay_d | seq_d | hdr_d);
      err_d    = pay_d | seq_d | hdr_d;
      exp_ch_d = rx_ch_q + 4'd1;
      exp_pn_d = rx_pn_q + 8'd1;
      seeded_d = 1'b1;
      locked_d = locked_q | ~hdr_d;
      state_d  = S_IDLE;
    end

    if (begin1) begin
      rx_ch_d = ts_data[3:0];
      hdr_d   = |ts_data[31:4];
      pay_d   = 1'b0;
      seq_d   = 1'b0;
      w_d     = 8'd1;
      if (ts_end) begin
        err_d   = 1'b1;
        code_d  = {2'b00, hdr_d, 1'b1};
        state_d = S_IDLE;
      end else begin
        state_d = S_HDR;
      end
    end

    pcnt_d = (ok_d && pcnt_q != 16'hFFFF) ? pcnt_q + 16'd1 : pcnt_q;
    ecnt_d = (err_d && ecnt_q != 16'hFFFF) ? ecnt_q + 16'd1 : ecnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      w_q      <= 8'd0;
      rx_ch_q  <= 4'd0;
      rx_pn_q  <= 8'd0;
      exp_ch_q <= 4'd0;
      exp_pn_q <= 8'd0;
      seeded_q <= 1'b0;
      hdr_q    <= 1'b0;
      pay_q    <= 1'b0;
      seq_q    <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 4'd0;
      pcnt_q   <= 16'd0;
      ecnt_q   <= 16'd0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      rx_ch_q  <= rx_ch_d;
      rx_pn_q  <= rx_pn_d;
      exp_ch_q <= exp_ch_d;
      exp_pn_q <= exp_pn_d;
      seeded_q <= seeded_d;
      hdr_q    <= hdr_d;
      pay_q    <= pay_d;
      seq_q    <= seq_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      code_q   <= code_d;
      pcnt_q   <= pcnt_d;
      ecnt_q   <= ecnt_d;
      locked_q <= locked_d;
    end
  end

  assign pkt_ok   = ok_q;
  assign pkt_err  = err_q;
  assign err_code = code_q;
  assign pkt_cnt  = pcnt_q;
  assign err_cnt  = ecnt_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_ts_chk.sv
// tb/tb_ts_chk.sv - directed self-checking bench for ts_chk
`timescale 1ns/1ps
module tb_ts_chk;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ts_data = 32'd0;
  logic        ts_valid = 1'b0;
  logic        ts_start = 1'b0;
  logic        ts_end = 1'b0;
  logic        pkt_ok, pkt_err, locked;
  logic [3:0]  err_code;
  logic [15:0] pkt_cnt, err_cnt;

  int npass = 0;
  int ntotal = 0;
  int nok = 0;
  int nerr = 0;
  int nboth = 0;

  ts_chk dut (
    .clk(clk), .rst(rst), .ts_data(ts_data), .ts_valid(ts_valid),
    .ts_start(ts_start), .ts_end(ts_end), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
    .err_code(err_code), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .locked(locked)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cycle(input logic v, input logic s, input logic e, input logic [31:0] d);
    ts_valid = v; ts_start = s; ts_end = e; ts_data = d;
    @(posedge clk); #1;
    if (pkt_ok) nok++;
    if (pkt_err) nerr++;
    if (pkt_ok && pkt_err) nboth++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    nok = 0; nerr = 0;
  endtask

  function automatic logic [31:0] pay_word(input int w);
    logic [7:0] b;
    b = 8'(4 * w - 9);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  task automatic send_pkt(input logic [3:0] ch, input logic [7:0] pn, input int bad_w,
                          input logic [31:0] bad_data, input int stop_w, input bit end_on_stop);
    logic [31:0] d;
    for (int w = 1; w <= stop_w; w++) begin
      if (w == 1) d = {28'd0, ch};
      else if (w == 2) d = {8'h47, pn, 16'h0102};
      else d = pay_word(w);
      if (w == bad_w) d = bad_data;
      cycle(1'b1, w == 1, (w == stop_w) && end_on_stop, d);
    end
  endtask

  task automatic good_pkt(input logic [3:0] ch, input logic [7:0] pn);
    send_pkt(ch, pn, 0, 32'd0, 48, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    ntotal++; if ({pkt_ok, pkt_err, err_code, locked} !== 7'd0) $display("FAIL reset_flags: got %b want 0", {pkt_ok, pkt_err, err_code, locked}); else npass++;
    ntotal++; if ({pkt_cnt, err_cnt} !== 32'd0) $display("FAIL reset_counts: got %h want 0", {pkt_cnt, err_cnt}); else npass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    good_pkt(4'd5, 8'd1);
    ntotal++; if (pkt_ok !== 1'b1) $display("FAIL b2b_pkt1_ok: got %b want 1", pkt_ok); else npass++;
    ntotal++; if (locked !== 1'b1) $display("FAIL b2b_locked: got %b want 1", locked); else npass++;
    good_pkt(4'd6, 8'd2);
    good_pkt(4'd7, 8'd3);
    ntotal++; if (pkt_ok !== 1'b1 || err_code !== 4'd0) $display("FAIL b2b_pkt3: got ok=%b code=%b want ok=1 code=0000", pkt_ok, err_code); else npass++;
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    ntotal++; if (pkt_ok !== 1'b0) $display("FAIL b2b_pulse_width: got %b want 0", pkt_ok); else npass++;
    ntotal++; if (pkt_cnt !== 16'd3 || err_cnt !== 16'd0) $display("FAIL b2b_counts: got %0d/%0d want 3/0", pkt_cnt, err_cnt); else npass++;
    ntotal++; if (nok !== 3 || nerr !== 0) $display("FAIL b2b_pulses: got ok=%0d err=%0d want 3/0", nok, nerr); else npass++;
  endtask

  task automatic test_payload();
    do_reset();
    good_pkt(4'd0, 8'd0);
    send_pkt(4'd1, 8'd1, 10, 32'h1F20_2100, 48, 1'b1);
    ntotal++; if (pkt_err !== 1'b1 || err_code !== 4'b1000) $display("FAIL payload_err: got err=%b code=%b want 1/1000", pkt_err, err_code); else npass++;
    good_pkt(4'd2, 8'd2);
    ntotal++; if (pkt_ok !== 1'b1 || err_code !== 4'b0000) $display("FAIL payload_next_ok: got ok=%b code=%b want 1/0000", pkt_ok, err_code); else npass++;
    ntotal++; if (pkt_cnt !== 16'd2 || err_cnt !== 16'd1) $display("FAIL payload_counts: got %0d/%0d want 2/1", pkt_cnt, err_cnt); else npass++;
  endtask

  task automatic test_sequence();
    do_reset();
    good_pkt(4'd3, 8'd1);
    good_pkt(4'd4, 8'd2);
    good_pkt(4'd5, 8'd4);
    ntotal++; if (pkt_err !== 1'b1 || err_code !== 4'b0100) $display("FAIL seq_err: got err=%b code=%b want 1/0100", pkt_err, err_code); else npass++;
    good_pkt(4'd6, 8'd5);
    ntotal++; if (pkt_ok !== 1'b1) $display("FAIL seq_resync: got %b want 1", pkt_ok); else npass++;
    ntotal++; if (nok !== 3 || nerr !== 1) $display("FAIL seq_pulses: got ok=%0d err=%0d want 3/1", nok, nerr); else npass++;
  endtask

  task automatic test_wrap();
    do_reset();
    good_pkt(4'hE, 8'hFE);
    good_pkt(4'hF, 8'hFF);
    good_pkt(4'h0, 8'h00);
    ntotal++; if (pkt_ok !== 1'b1 || err_code !== 4'd0) $display("FAIL wrap_ok: got ok=%b code=%b want 1/0000", pkt_ok, err_code); else npass++;
    ntotal++; if (pkt_cnt !== 16'd3 || err_cnt !== 16'd0) $display("FAIL wrap_counts: got %0d/%0d want 3/0", pkt_cnt, err_cnt); else npass++;
  endtask

  task automatic test_framing();
    do_reset();
    good_pkt(4'd1, 8'd1);
    send_pkt(4'd2, 8'd2, 0, 32'd0, 47, 1'b1);
    ntotal++; if (pkt_err !== 1'b1 || err_code !== 4'b0001) $display("FAIL frame_early_end: got err=%b code=%b want 1/0001", pkt_err, err_code); else npass++;
    good_pkt(4'd2, 8'd2);
    ntotal++; if (pkt_ok !== 1'b1) $display("FAIL frame_retry_ok: got %b want 1", pkt_ok); else npass++;
    send_pkt(4'd3, 8'd3, 0, 32'd0, 19, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    ntotal++; if (pkt_err !== 1'b1 || err_code !== 4'b0001) $display("FAIL frame_gap: got err=%b code=%b want 1/0001", pkt_err, err_code); else npass++;
    cycle(1'b1, 1'b0, 1'b0, pay_word(21));
    ntotal++; if (pkt_ok !== 1'b0 || pkt_err !== 1'b0) $display("FAIL frame_idle_discard: got ok=%b err=%b want 0/0", pkt_ok, pkt_err); else npass++;
    good_pkt(4'd3, 8'd3);
    ntotal++; if (pkt_ok !== 1'b1) $display("FAIL frame_recover_ok: got %b want 1", pkt_ok); else npass++;
    ntotal++; if (pkt_cnt !== 16'd3 || err_cnt !== 16'd2) $display("FAIL frame_counts: got %0d/%0d want 3/2", pkt_cnt, err_cnt); else npass++;
  endtask

  task automatic test_header_and_rst();
    do_reset();
    send_pkt(4'd1, 8'd1, 2, 32'h4601_0102, 48, 1'b1);
    ntotal++; if (pkt_err !== 1'b1 || err_code !== 4'b0010) $display("FAIL hdr_err: got err=%b code=%b want 1/0010", pkt_err, err_code); else npass++;
    ntotal++; if (locked !== 1'b0) $display("FAIL hdr_not_locked: got %b want 0", locked); else npass++;
    send_pkt(4'd2, 8'd2, 0, 32'd0, 29, 1'b0);
    do_reset();
    ntotal++; if ({pkt_ok, pkt_err, err_code, locked, pkt_cnt, err_cnt} !== 39'd0) $display("FAIL rst_mid_pkt: got %h want 0", {pkt_ok, pkt_err, err_code, locked, pkt_cnt, err_cnt}); else npass++;
    good_pkt(4'd9, 8'h50);
    ntotal++; if (pkt_ok !== 1'b1 || pkt_cnt !== 16'd1) $display("FAIL rst_seed_only: got ok=%b cnt=%0d want 1/1", pkt_ok, pkt_cnt); else npass++;
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    ntotal++; if (nok !== 1 || nerr !== 0) $display("FAIL rst_no_partial_report: got ok=%0d err=%0d want 1/0", nok, nerr); else npass++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_payload();
    test_sequence();
    test_wrap();
    test_framing();
    test_header_and_rst();
    ntotal++; if (nboth !== 0) $display("FAIL ok_err_exclusive: got %0d overlaps want 0", nboth); else npass++;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
